// File: rtl/pll_reset_ctrl.sv
// PLL supervisor: pulses the PLL reset, waits for lock, qualifies it as stable,
// then releases the system reset. It retries on lock timeout and requalifies after loss of lock.
module pll_reset_ctrl #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] unlock_cnt
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAIL      = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [7:0]       unlock_q, unlock_d;
    logic             sync1_q, locked_s_q;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        unlock_d = unlock_q;
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // A lock seen in the timeout cycle wins over the retry.
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retry_q == RETRY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s_q) begin
                    state_d = S_WAIT_LOCK;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = 4'd0;
                end
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    state_d  = S_WAIT_LOCK;
                    unlock_d = sat_inc8(unlock_q);
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
            end
        endcase

        if (restart) begin
            state_d  = S_RESET_PLL;
            retry_d  = 4'd0;
            unlock_d = unlock_q;
        end

        cnt_d = cnt_q;
        if (restart || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (state_q == S_RESET_PLL || state_q == S_WAIT_LOCK || state_q == S_STABLE) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs are decoded from the next state so they register in step with it.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= S_RESET_PLL;
            cnt_q      <= '0;
            retry_q    <= 4'd0;
            unlock_q   <= 8'd0;
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            pll_rst_q  <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            unlock_q   <= unlock_d;
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
            pll_rst_q  <= pll_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign pll_rst    = pll_rst_q;
    assign sys_rst    = sys_rst_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;
    assign unlock_cnt = unlock_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: stimulus pushes cycle-stamped expectations into a queue,
// and a negedge monitor pops and compares them against the outputs.
module tb_pll_reset_ctrl;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] unlock_cnt;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES (8),
        .MAX_RETRIES        (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .restart   (restart),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .unlock_cnt(unlock_cnt)
    );

    initial forever #5 refclk = ~refclk;

    localparam int SEL_PLLRST = 0;
    localparam int SEL_SYSRST = 1;
    localparam int SEL_READY  = 2;
    localparam int SEL_FAIL   = 3;
    localparam int SEL_RETRY  = 4;
    localparam int SEL_UNLOCK = 5;

    typedef struct {
        int    cyc;
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge refclk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            SEL_PLLRST: return int'(pll_rst);
            SEL_SYSRST: return int'(sys_rst);
            SEL_READY:  return int'(ready);
            SEL_FAIL:   return int'(fail);
            SEL_RETRY:  return int'(retry_cnt);
            SEL_UNLOCK: return int'(unlock_cnt);
            default:    return -1;
        endcase
    endfunction

    task automatic expect_at(input int dly, input string tag, input int sel, input int val);
        exp_t e;
        e.cyc = cyc + dly;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    always @(negedge refclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, sample(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    initial begin
        int c0, l0, n0, m0, a0, r0, f0, g0;
        rst        = 1'b0;
        pll_locked = 1'b0;
        restart    = 1'b0;

        // Reset values while rst is high, before and after clock edges.
        #2 rst = 1'b1;
        #1;
        check("rst_pll_rst", int'(pll_rst), 1);
        check("rst_sys_rst", int'(sys_rst), 1);
        check("rst_ready", int'(ready), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_retry", int'(retry_cnt), 0);
        check("rst_unlock", int'(unlock_cnt), 0);
        repeat (3) @(negedge refclk);
        check("rst_hold_pll_rst", int'(pll_rst), 1);
        check("rst_hold_sys_rst", int'(sys_rst), 1);

        // Normal bring-up.
        c0 = cyc;
        rst = 1'b0;
        expect_at(1, "bu_pllrst_1", SEL_PLLRST, 1);
        expect_at(3, "bu_pllrst_3", SEL_PLLRST, 1);
        expect_at(4, "bu_pllrst_fall", SEL_PLLRST, 0);
        expect_at(4, "bu_sysrst_wait", SEL_SYSRST, 1);
        goto(c0 + 10);
        l0 = cyc;
        pll_locked = 1'b1;
        expect_at(10, "bu_sysrst_pre", SEL_SYSRST, 1);
        expect_at(11, "bu_sysrst_rel", SEL_SYSRST, 0);
        expect_at(10, "bu_ready_pre", SEL_READY, 0);
        expect_at(11, "bu_ready", SEL_READY, 1);
        expect_at(11, "bu_retry", SEL_RETRY, 0);
        expect_at(11, "bu_pllrst_run", SEL_PLLRST, 0);
        goto(l0 + 11);

        // Repeated loss of lock in RUN; the unlock counter saturates.
        for (int k = 1; k <= 300; k++) begin
            n0 = cyc;
            pll_locked = 1'b0;
            expect_at(2, "ul_ready_hold", SEL_READY, 1);
            expect_at(3, "ul_ready_drop", SEL_READY, 0);
            expect_at(3, "ul_sysrst", SEL_SYSRST, 1);
            expect_at(3, "ul_pllrst", SEL_PLLRST, 0);
            expect_at(3, "ul_cnt", SEL_UNLOCK, (k < 255) ? k : 255);
            goto(n0 + 4);
            m0 = cyc;
            pll_locked = 1'b1;
            expect_at(10, "ul_ready_pre", SEL_READY, 0);
            expect_at(11, "ul_relock", SEL_READY, 1);
            goto(m0 + 11);
        end

        // Flaky qualification: high 5, low 1, then high.
        n0 = cyc;
        pll_locked = 1'b0;
        expect_at(3, "fq_unlock_sat", SEL_UNLOCK, 255);
        goto(n0 + 4);
        a0 = cyc;
        pll_locked = 1'b1;
        expect_at(11, "fq_no_early_rel", SEL_SYSRST, 1);
        expect_at(16, "fq_sysrst_pre", SEL_SYSRST, 1);
        expect_at(17, "fq_sysrst", SEL_SYSRST, 0);
        expect_at(17, "fq_ready", SEL_READY, 1);
        expect_at(17, "fq_retry", SEL_RETRY, 0);
        goto(a0 + 5);
        pll_locked = 1'b0;
        goto(a0 + 6);
        pll_locked = 1'b1;
        goto(a0 + 17);

        // Restart from RUN with lock never arriving: three pulses, then FAIL.
        r0 = cyc;
        restart = 1'b1;
        pll_locked = 1'b0;
        expect_at(1, "nl_ready_off", SEL_READY, 0);
        expect_at(1, "nl_pllrst_p1", SEL_PLLRST, 1);
        expect_at(4, "nl_pllrst_p1e", SEL_PLLRST, 1);
        expect_at(5, "nl_pllrst_w1", SEL_PLLRST, 0);
        expect_at(10, "nl_unlock_kept", SEL_UNLOCK, 255);
        expect_at(24, "nl_pllrst_w1e", SEL_PLLRST, 0);
        expect_at(24, "nl_retry0", SEL_RETRY, 0);
        expect_at(25, "nl_pllrst_p2", SEL_PLLRST, 1);
        expect_at(25, "nl_retry1", SEL_RETRY, 1);
        expect_at(28, "nl_pllrst_p2e", SEL_PLLRST, 1);
        expect_at(29, "nl_pllrst_w2", SEL_PLLRST, 0);
        expect_at(48, "nl_retry1_hold", SEL_RETRY, 1);
        expect_at(49, "nl_pllrst_p3", SEL_PLLRST, 1);
        expect_at(49, "nl_retry2", SEL_RETRY, 2);
        expect_at(52, "nl_pllrst_p3e", SEL_PLLRST, 1);
        expect_at(53, "nl_pllrst_w3", SEL_PLLRST, 0);
        expect_at(72, "nl_fail_pre", SEL_FAIL, 0);
        expect_at(72, "nl_pllrst_w3e", SEL_PLLRST, 0);
        expect_at(73, "nl_fail", SEL_FAIL, 1);
        expect_at(73, "nl_pllrst_park", SEL_PLLRST, 1);
        expect_at(73, "nl_retry_fail", SEL_RETRY, 2);
        expect_at(90, "nl_fail_hold", SEL_FAIL, 1);
        expect_at(90, "nl_pllrst_hold", SEL_PLLRST, 1);
        expect_at(90, "nl_sysrst_hold", SEL_SYSRST, 1);
        goto(r0 + 1);
        restart = 1'b0;
        goto(r0 + 90);

        // Restart out of FAIL, then again in the middle of STABLE.
        f0 = cyc;
        restart = 1'b1;
        expect_at(1, "rs_fail_clr", SEL_FAIL, 0);
        expect_at(1, "rs_retry_clr", SEL_RETRY, 0);
        expect_at(1, "rs_pllrst", SEL_PLLRST, 1);
        expect_at(4, "rs_pllrst_e", SEL_PLLRST, 1);
        expect_at(5, "rs_pllrst_fall", SEL_PLLRST, 0);
        expect_at(1, "rs_unlock", SEL_UNLOCK, 255);
        goto(f0 + 1);
        restart = 1'b0;
        goto(f0 + 6);
        pll_locked = 1'b1;
        goto(f0 + 12);
        g0 = cyc;
        restart = 1'b1;
        expect_at(1, "rs2_retry", SEL_RETRY, 0);
        expect_at(1, "rs2_pllrst", SEL_PLLRST, 1);
        expect_at(1, "rs2_sysrst", SEL_SYSRST, 1);
        expect_at(4, "rs2_pllrst_e", SEL_PLLRST, 1);
        expect_at(5, "rs2_pllrst_fall", SEL_PLLRST, 0);
        expect_at(13, "rs2_ready_pre", SEL_READY, 0);
        expect_at(14, "rs2_ready", SEL_READY, 1);
        expect_at(14, "rs2_unlock", SEL_UNLOCK, 255);
        goto(g0 + 1);
        restart = 1'b0;
        goto(g0 + 14);

        // Asynchronous reset mid-RUN, between clock edges.
        #3 rst = 1'b1;
        #1;
        check("ar_sys_rst", int'(sys_rst), 1);
        check("ar_pll_rst", int'(pll_rst), 1);
        check("ar_ready", int'(ready), 0);
        check("ar_unlock", int'(unlock_cnt), 0);
        check("ar_fail", int'(fail), 0);
        check("ar_retry", int'(retry_cnt), 0);
        repeat (2) @(negedge refclk);
        c0 = cyc;
        rst = 1'b0;
        expect_at(3, "ar2_pllrst_e", SEL_PLLRST, 1);
        expect_at(4, "ar2_pllrst_fall", SEL_PLLRST, 0);
        expect_at(12, "ar2_ready_pre", SEL_READY, 0);
        expect_at(13, "ar2_ready", SEL_READY, 1);
        expect_at(13, "ar2_unlock", SEL_UNLOCK, 0);
        goto(c0 + 15);

        check("sb_leftover", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
